// File: rtl/translayer_pkg.sv
// Shared definitions for the transaction-layer controller: state encoding,
// FIFO index map and default sizing.
package translayer_pkg;

    localparam int DEPTH_DEF  = 8;
    localparam int NFIFO_DEF  = 5;
    localparam int DEF_TH_DEF = 1;

    localparam int IDX_MAIN = 0;
    localparam int IDX_VC0  = 1;
    localparam int IDX_VC1  = 2;
    localparam int IDX_D0   = 3;
    localparam int IDX_D1   = 4;

    typedef enum logic [4:0] {
        ST_RESET  = 5'b00001,
        ST_INIT   = 5'b00010,
        ST_IDLE   = 5'b00100,
        ST_ACTIVE = 5'b01000,
        ST_ERROR  = 5'b10000
    } state_e;

endpackage

// File: rtl/translayer_th_clamp.sv
// Combinational clamp of a requested FIFO threshold into the legal range
// [1, DEPTH-1].
module translayer_th_clamp
    import translayer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic [7:0] th_i,
    output logic [7:0] th_o
);

    always_comb begin
        th_o = th_i;
        if (th_i == 8'd0) begin
            th_o = 8'd1;
        end else if (th_i >= 8'(DEPTH)) begin
            th_o = 8'(DEPTH - 1);
        end
    end

endmodule

// File: rtl/translayer_ctrl_fsm.sv
// Transaction-layer sequencing controller: RESET/INIT/IDLE/ACTIVE/ERROR FSM,
// threshold capture, push/pop gating and registered status outputs.
module translayer_ctrl_fsm
    import translayer_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int NFIFO  = NFIFO_DEF,
    parameter int DEF_TH = DEF_TH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic [7:0]       UMF,
    input  logic [7:0]       UVC,
    input  logic [7:0]       UD,
    input  logic [NFIFO-1:0] fifo_empty,
    input  logic [NFIFO-1:0] fifo_error,
    output logic [7:0]       umf_th,
    output logic [7:0]       uvc_th,
    output logic [7:0]       ud_th,
    output logic             push_en,
    output logic             pop_en,
    output logic [4:0]       state_out,
    output logic             idle_out,
    output logic             active_out,
    output logic             error_out,
    output logic [NFIFO-1:0] err_src
);

    state_e           state_q, state_d;
    logic [7:0]       umf_q, umf_d, uvc_q, uvc_d, ud_q, ud_d;
    logic [7:0]       umf_cl, uvc_cl, ud_cl;
    logic [NFIFO-1:0] err_src_q, err_src_d;
    logic [4:0]       st_out_q, st_out_d;
    logic             en_q, en_d;
    logic             idle_q, idle_d, act_q, act_d, err_q, err_d;

    translayer_th_clamp #(.DEPTH(DEPTH)) u_clamp_umf (.th_i(UMF), .th_o(umf_cl));
    translayer_th_clamp #(.DEPTH(DEPTH)) u_clamp_uvc (.th_i(UVC), .th_o(uvc_cl));
    translayer_th_clamp #(.DEPTH(DEPTH)) u_clamp_ud  (.th_i(UD),  .th_o(ud_cl));

    always_comb begin
        state_d   = state_q;
        umf_d     = umf_q;
        uvc_d     = uvc_q;
        ud_d      = ud_q;
        err_src_d = err_src_q;

        case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT: begin
                umf_d = umf_cl;
                uvc_d = uvc_cl;
                ud_d  = ud_cl;
                if (!init) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                // Error outranks a re-init request, which outranks occupancy.
                if (|fifo_error)      state_d = ST_ERROR;
                else if (init)        state_d = ST_INIT;
                else if (!(&fifo_empty)) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (|fifo_error)      state_d = ST_ERROR;
                else if (init)        state_d = ST_INIT;
                else if (&fifo_empty) state_d = ST_IDLE;
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_RESET;
        endcase

        if (state_q inside {ST_IDLE, ST_ACTIVE, ST_ERROR}) begin
            err_src_d = err_src_q | fifo_error;
        end

        // Status outputs are a registered copy of the current state decode.
        st_out_d = state_q;
        en_d     = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
        idle_d   = (state_q == ST_IDLE);
        act_d    = (state_q == ST_ACTIVE);
        err_d    = (state_q == ST_ERROR);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_RESET;
            umf_q     <= 8'(DEF_TH);
            uvc_q     <= 8'(DEF_TH);
            ud_q      <= 8'(DEF_TH);
            err_src_q <= '0;
            st_out_q  <= ST_RESET;
            en_q      <= 1'b0;
            idle_q    <= 1'b0;
            act_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            umf_q     <= umf_d;
            uvc_q     <= uvc_d;
            ud_q      <= ud_d;
            err_src_q <= err_src_d;
            st_out_q  <= st_out_d;
            en_q      <= en_d;
            idle_q    <= idle_d;
            act_q     <= act_d;
            err_q     <= err_d;
        end
    end

    assign umf_th     = umf_q;
    assign uvc_th     = uvc_q;
    assign ud_th      = ud_q;
    assign push_en    = en_q;
    assign pop_en     = en_q;
    assign state_out  = st_out_q;
    assign idle_out   = idle_q;
    assign active_out = act_q;
    assign error_out  = err_q;
    assign err_src    = err_src_q;

endmodule

// File: doc/translayer_ctrl_fsm.md
Name: translayer_ctrl_fsm

Overview:
Central sequencing controller for the transaction layer (main FIFO, two virtual-channel FIFOs, two destination FIFOs).
- Runs the RESET/INIT/IDLE/ACTIVE/ERROR state machine.
- Captures and clamps the UMF/UVC/UD almost-full/almost-empty thresholds and distributes them to the FIFOs.
- Gates push/pop enables and reports idle/active/error status to the probador and upper layers.

Parameters:
DEPTH, 8, entries per FIFO; thresholds are clamped to 1..DEPTH-1.
NFIFO, 5, number of monitored FIFOs (bit 0 main, 1 vc0, 2 vc1, 3 d0, 4 d1).
DEF_TH, 1, threshold value loaded in reset.

Ports:
clk  in  1  system clock; all logic on the rising edge.
reset  in  1  synchronous, active-low reset.
init  in  1  request to (re)enter INIT and reload thresholds.
UMF  in  8  requested main-FIFO threshold.
UVC  in  8  requested VC-FIFO threshold.
UD  in  8  requested destination-FIFO threshold.
fifo_empty  in  NFIFO  empty flag per FIFO.
fifo_error  in  NFIFO  overflow/underflow pulse per FIFO.
umf_th  out  8  applied main-FIFO threshold.
uvc_th  out  8  applied VC threshold.
ud_th  out  8  applied destination threshold.
push_en  out  1  high in IDLE/ACTIVE only.
pop_en  out  1  high in IDLE/ACTIVE only.
state_out  out  5  one-hot state.
idle_out  out  1  state==IDLE.
active_out  out  1  state==ACTIVE.
error_out  out  1  state==ERROR.
err_src  out  NFIFO  sticky record of which FIFO(s) raised an error.

Behaviour:
- Moore machine. All outputs are registered, and a condition sampled at edge N is visible after edge N+1.
- One-hot encoding: RESET=5'b00001, INIT=5'b00010, IDLE=5'b00100, ACTIVE=5'b01000, ERROR=5'b10000.
- reset==0 at an edge:
  - state=RESET; thresholds=DEF_TH; err_src=0.
  - push_en, pop_en, idle_out, active_out, error_out all 0.
  - Reset overrides everything, including a mid-operation ERROR.
- RESET -> INIT unconditionally on the first edge with reset==1.
- INIT:
  - Each cycle, umf_th/uvc_th/ud_th load the clamped inputs: 0 -> 1; >=DEPTH -> DEPTH-1; otherwise unchanged.
  - Stay while init==1; init==0 -> IDLE.
  - fifo_error is ignored in INIT (FIFOs are held off).
- IDLE: priority error > init > occupancy.
  - Any fifo_error bit -> ERROR.
  - Else init==1 -> INIT.
  - Else any fifo_empty bit 0 -> ACTIVE.
  - Else stay.
- ACTIVE: same priority.
  - fifo_error -> ERROR.
  - Else init -> INIT.
  - Else all fifo_empty==1 -> IDLE.
  - Else stay.
- ERROR:
  - Sticky; init does not exit. Only reset exits.
  - err_src ORs in fifo_error every cycle while in IDLE/ACTIVE/ERROR; it is never cleared except by reset.
- Thresholds hold their value in every state except INIT and RESET.
- push_en/pop_en are 0 in RESET, INIT and ERROR.
- idle_out/active_out/error_out are decoded from the state register and are mutually exclusive.
- Simultaneous init and fifo_error in IDLE/ACTIVE: ERROR wins.
- Simultaneous init=1 and reset=0: RESET wins.

Decomposition:
- Shared package translayer_pkg holds:
  - state encoding localparams (ST_RESET..ST_ERROR).
  - FIFO index constants (IDX_MAIN=0, IDX_VC0=1, IDX_VC1=2, IDX_D0=3, IDX_D1=4).
  - DEPTH default.
- One natural sub-module: translayer_th_clamp, a combinational 8-bit clamp to [1, DEPTH-1], instantiated three times.
- The state register and next-state logic stay in the top module.

Test Plan:
1. Reset and INIT load:
   - Stimulus: reset=0 for 2 cycles, then reset=1 with init=1, UMF=4, UVC=3, UD=2; release init after 3 cycles.
   - Response: state RESET -> INIT -> IDLE (5'b00100); umf_th=4, uvc_th=3, ud_th=2; push_en=1 the cycle after entering IDLE.
2. Threshold clamping:
   - Stimulus: in INIT, drive UMF=0, UVC=8, UD=200.
   - Response: umf_th=1, uvc_th=7, ud_th=7.
   - Then leave INIT and change UMF to 5: umf_th stays 1.
3. Occupancy tracking:
   - Stimulus: from IDLE, fifo_empty=5'b11110 for 4 cycles, then 5'b11111.
   - Response: active_out=1 one cycle after the first non-empty sample, for 4 cycles; idle_out=1 one cycle after all-empty.
4. Error priority and stickiness:
   - Stimulus: in ACTIVE, pulse fifo_error=5'b01000 with init=1 in the same cycle; then init=1 for 5 cycles.
   - Response: error_out=1, err_src=5'b01000, push_en=pop_en=0; state remains ERROR throughout.
5. Reset from ERROR:
   - Stimulus: in ERROR, reset=0 for 1 cycle.
   - Response: err_src=0, thresholds=1, state=RESET, then INIT on the next edge.
6. Re-init from ACTIVE:
   - Stimulus: init=1 while ACTIVE, with UD=6.
   - Response: INIT next cycle, push_en=0, ud_th=6; IDLE or ACTIVE after init drops, according to fifo_empty.
